uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver: configurable data width, stop-bit count and bit period, optional parity check, and framing-error reporting. Asynchronous active-low reset. Sits between the board RX pin and the command/byte-stream consumer. A single-cycle valid pulse qualifies the received word and its error flags.

## Interface

Parameters:
- CLKS_PER_BIT, 200: clock cycles per bit, range 4..65535; counter is 16 bits.
- DATA_BITS, 8: data bits per frame, range 5..8; LSB first.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.

Ports:
- i_Clock, input, 1: sole clock; everything is rising-edge.
- i_Rst_L, input, 1: asynchronous, active-low reset.
- i_Rx_Serial, input, 1: asynchronous serial line; idles high.
- o_Rx_DV, output, 1: one-cycle pulse when a frame completes.
- o_Rx_Byte, output, DATA_BITS: last received word; updated only when o_Rx_DV pulses.
- o_Frame_Err, output, 1: first stop bit was sampled low; updated with o_Rx_DV and held until the next o_Rx_DV.
- o_Parity_Err, output, 1: parity mismatch; updated with o_Rx_DV and held. Tied to 0 when parity is not compiled in.
- o_Busy, output, 1: high in every state except IDLE.

## Operation

- Input path: two-flop synchroniser on i_Rx_Serial. Both flops reset to 1. All decisions use the second flop, called rx_s.
- Half-bit point: H = (CLKS_PER_BIT-1)/2, integer division.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - Counter and bit index are cleared.
  - rx_s = 0 -> START.
- START:
  - Count to H.
  - At H: if rx_s = 0, clear the counter -> DATA. If rx_s = 1 (glitch), -> IDLE with no DV and no flag change.
- DATA:
  - Each bit is sampled when the counter reaches CLKS_PER_BIT-1; the counter then clears.
  - Bit i goes to shift position i.
  - After bit DATA_BITS-1: -> PARITY if compiled in, else -> STOP.
- PARITY: sample one bit the same way. Error when (XOR of data bits XOR parity bit) != PARITY_ODD.
- STOP:
  - Sample each stop bit at CLKS_PER_BIT-1.
  - Only the first stop bit is checked for framing; the second stop bit is sampled but ignored.
  - After the last stop sample, on the next edge: o_Rx_DV = 1, o_Rx_Byte = shift register, and both error flags are loaded.
  - Then -> IDLE if the last sample was 1, else -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then -> IDLE. This prevents a stuck-low line or break from being decoded as back-to-back frames.
- Unused state encodings -> IDLE.
- Reset, at any time including mid-frame, forces:
  - state to IDLE;
  - counter and bit index to 0;
  - o_Rx_DV, o_Rx_Byte, o_Frame_Err and o_Parity_Err to 0;
  - o_Busy to 0;
  - synchroniser flops to 1.
  - No partial frame is ever reported.

## Timing

- Synchroniser latency: 2 cycles from i_Rx_Serial to rx_s.
- Start bit: the START middle-check happens H+1 cycles after IDLE first sees rx_s = 0.
- Data bit k (k from 0) is sampled (k+1)*CLKS_PER_BIT cycles after the start mid-check.
- The parity bit is sampled CLKS_PER_BIT after the last data bit.
- Stop bits are sampled at consecutive CLKS_PER_BIT intervals after that.
- o_Rx_DV:
  - Rises one cycle after the last stop sample; high for exactly one cycle.
  - Never two pulses closer than one full frame.
- Ready for the next start edge the cycle after o_Rx_DV, provided the stop bit was high. This tolerates a sender up to one half-bit fast.
- Outputs are registered; there is no combinational path from i_Rx_Serial.

## Configuration

- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state is present and one parity bit is expected after the data bits. o_Parity_Err is computed per PARITY_ODD.
- Undefined: PARITY is removed and the frame has no parity bit. o_Parity_Err is constant 0 and PARITY_ODD is ignored.

## Test plan

All scenarios use CLKS_PER_BIT = 16, DATA_BITS = 8 and STOP_BITS = 1 unless stated.

- Send 0xA5 (8N1) -> one o_Rx_DV pulse, o_Rx_Byte = 0xA5, both error flags 0. o_Busy falls the cycle after the DV.
- Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three DV pulses in order with matching bytes. The pulses are spaced exactly 10*16 cycles apart.
- 0x55 with the stop bit driven low, then the line held low for 40 bits, then released -> exactly one DV, o_Rx_Byte = 0x55, o_Frame_Err = 1. No further DV until a new valid frame follows the release.
- A 5-cycle low glitch on an idle line -> return to IDLE, no DV, and outputs unchanged from their previous values.
- With UART_RX_PARITY_EN, even parity: 0x07 with parity bit 1 -> o_Parity_Err = 0. 0x07 with parity bit 0 -> o_Parity_Err = 1. Repeat with PARITY_ODD = 1 and expect the inverse results.
- i_Rst_L asserted low during data bit 4 of a frame -> all outputs 0 immediately. After release, the remainder of the frame does not produce a DV, and the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with framing and optional parity checking.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);

  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_HALF  = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic        PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  logic sync1;
  logic rx_s;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_Rx_Serial;
      rx_s  <= sync1;
    end
  end

  state_t               state;
  logic [15:0]          cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_err;
  logic                 done;
  logic                 last_stop;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_err   <= 1'b0;
      done        <= 1'b0;
      last_stop   <= 1'b1;
      o_Rx_DV     <= 1'b0;
      o_Rx_Byte   <= '0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      o_Rx_DV <= 1'b0;
      // Busy lags the state by one cycle so it stays high through the DV cycle
      o_Busy  <= (state != IDLE);
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          done    <= 1'b0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            parity_err <= ((^shift) ^ rx_s) != PAR_ODD;
            state      <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          // The report is issued one edge after the final stop sample
          if (done) begin
            o_Rx_DV      <= 1'b1;
            o_Rx_Byte    <= shift;
            o_Frame_Err  <= frame_err;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= parity_err;
`endif
            done    <= 1'b0;
            bit_idx <= '0;
            state   <= last_stop ? IDLE : WAIT_HIGH;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd0) frame_err <= ~rx_s;
            if (bit_idx == LAST_STOP) begin
              done      <= 1'b1;
              last_stop <= rx_s;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_Parity_Err = PAR_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg (CLKS_PER_BIT=16, 8 data bits, 1 stop bit).
// With UART_RX_PARITY_EN a second, odd-parity instance shares the serial line.
module tb_uart_rx_cfg;
  localparam int unsigned CPB = 16;
  localparam int unsigned HB  = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
  localparam int unsigned FB     = 11;
`else
  localparam bit          PAR_EN = 1'b0;
  localparam int unsigned FB     = 10;
`endif
  // start drive -> 2 sync + 1 IDLE edge, H+1 to mid-start, (FB-1) bits to last stop, +1 to DV
  localparam int unsigned LAT = 3 + (HB + 1) + (FB - 1) * CPB + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx    = 1'b1;
  logic       dv, fe, pe, busy, pe_odd;
  logic [7:0] rbyte;
  int unsigned total = 0, bad = 0, cyc = 0;
  logic [7:0] last_b;
  logic       last_fe, last_pe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx), .o_Rx_DV(dv), .o_Rx_Byte(rbyte),
    .o_Frame_Err(fe), .o_Parity_Err(pe), .o_Busy(busy));

`ifdef UART_RX_PARITY_EN
  logic       dv2, fe2, busy2;
  logic [7:0] byte2;
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut_odd (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
    .o_Frame_Err(fe2), .o_Parity_Err(pe_odd), .o_Busy(busy2));
`else
  assign pe_odd = 1'b0;
`endif

  typedef struct {
    logic [7:0]  b;
    logic        fe;
    logic        pe;
    logic        po;
    int unsigned t;
  } ev_t;
  ev_t  evq[$];
  logic busy_at_dv = 1'b0, busy_after_dv = 1'b1, dv_d = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (dv_d) busy_after_dv = busy;
    if (dv) begin
      e.b = rbyte; e.fe = fe; e.pe = pe; e.po = pe_odd; e.t = cyc;
      evq.push_back(e);
      busy_at_dv = busy;
    end
    dv_d = dv;
  end

  // Reference rule: error when XOR(data) ^ parity bit differs from the odd-select
  function automatic logic exp_pe(input logic [7:0] d, input logic p, input logic odd);
    return PAR_EN && ((((^d) ^ p)) != odd);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stopv,
                            output int unsigned t0);
    t0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = p;
      repeat (CPB) @(negedge clk);
    end
    rx = stopv;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (dv !== 1'b0)    begin bad++; $display("FAIL reset_dv got=%b exp=0", dv); end
    total++; if (rbyte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", rbyte); end
    total++; if (fe !== 1'b0)    begin bad++; $display("FAIL reset_fe got=%b exp=0", fe); end
    total++; if (pe !== 1'b0)    begin bad++; $display("FAIL reset_pe got=%b exp=0", pe); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single;
    int unsigned t0;
    logic [7:0]  d = 8'hA5;
    evq.delete();
    send_frame(d, ^d, 1'b1, t0);
    repeat (CPB) @(negedge clk);
    total++; if (evq.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", evq.size()); end
    if (evq.size() >= 1) begin
      total++; if (evq[0].b !== d)     begin bad++; $display("FAIL single_byte got=%h exp=%h", evq[0].b, d); end
      total++; if (evq[0].fe !== 1'b0) begin bad++; $display("FAIL single_fe got=%b exp=0", evq[0].fe); end
      total++; if (evq[0].pe !== 1'b0) begin bad++; $display("FAIL single_pe got=%b exp=0", evq[0].pe); end
      total++; if (evq[0].t - t0 !== LAT) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", evq[0].t - t0, LAT); end
    end
    total++; if (busy_at_dv !== 1'b1)    begin bad++; $display("FAIL busy_at_dv got=%b exp=1", busy_at_dv); end
    total++; if (busy_after_dv !== 1'b0) begin bad++; $display("FAIL busy_after_dv got=%b exp=0", busy_after_dv); end
    total++; if (rbyte !== d) begin bad++; $display("FAIL single_hold got=%h exp=%h", rbyte, d); end
    last_b = d; last_fe = 1'b0; last_pe = 1'b0;
  endtask

  task automatic test_back_to_back;
    int unsigned t0;
    logic [7:0]  d;
    logic        p;
    logic [7:0]  eb[$];
    logic        ep[$], epo[$];
    evq.delete();
    for (int i = 0; i < 8; i++) begin
      d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h3C : 8'($urandom);
      p = PAR_EN ? 1'($urandom) : 1'b0;
      eb.push_back(d); ep.push_back(exp_pe(d, p, 1'b0)); epo.push_back(exp_pe(d, p, 1'b1));
      send_frame(d, p, 1'b1, t0);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (evq.size() !== eb.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", evq.size(), eb.size()); end
    for (int i = 0; i < evq.size() && i < eb.size(); i++) begin
      total++; if (evq[i].b !== eb[i])   begin bad++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, evq[i].b, eb[i]); end
      total++; if (evq[i].fe !== 1'b0)   begin bad++; $display("FAIL b2b_fe[%0d] got=%b exp=0", i, evq[i].fe); end
      total++; if (evq[i].pe !== ep[i])  begin bad++; $display("FAIL b2b_pe[%0d] got=%b exp=%b", i, evq[i].pe, ep[i]); end
      total++; if (evq[i].po !== epo[i]) begin bad++; $display("FAIL b2b_pe_odd[%0d] got=%b exp=%b", i, evq[i].po, epo[i]); end
      if (i > 0) begin
        total++; if (evq[i].t - evq[i-1].t !== FB * CPB)
          begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, evq[i].t - evq[i-1].t, FB * CPB); end
      end
    end
    if (eb.size() > 0) begin
      last_b = eb[eb.size()-1]; last_fe = 1'b0; last_pe = ep[ep.size()-1];
    end
  endtask

  task automatic test_break;
    int unsigned t0;
    logic [7:0]  d;
    evq.delete();
    send_frame(8'h55, 1'b0, 1'b0, t0);
    repeat (40 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    total++; if (evq.size() !== 1) begin bad++; $display("FAIL break_count got=%0d exp=1", evq.size()); end
    if (evq.size() >= 1) begin
      total++; if (evq[0].b !== 8'h55) begin bad++; $display("FAIL break_byte got=%h exp=55", evq[0].b); end
      total++; if (evq[0].fe !== 1'b1) begin bad++; $display("FAIL break_fe got=%b exp=1", evq[0].fe); end
    end
    d = 8'($urandom);
    send_frame(d, ^d, 1'b1, t0);
    repeat (CPB) @(negedge clk);
    total++; if (evq.size() !== 2) begin bad++; $display("FAIL break_next_count got=%0d exp=2", evq.size()); end
    if (evq.size() >= 2) begin
      total++; if (evq[1].b !== d)     begin bad++; $display("FAIL break_next_byte got=%h exp=%h", evq[1].b, d); end
      total++; if (evq[1].fe !== 1'b0) begin bad++; $display("FAIL break_next_fe got=%b exp=0", evq[1].fe); end
    end
    last_b = d; last_fe = 1'b0; last_pe = 1'b0;
  endtask

  task automatic test_glitch;
    evq.delete();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++; if (evq.size() !== 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", evq.size()); end
    total++; if (rbyte !== last_b) begin bad++; $display("FAIL glitch_byte got=%h exp=%h", rbyte, last_b); end
    total++; if (fe !== last_fe)   begin bad++; $display("FAIL glitch_fe got=%b exp=%b", fe, last_fe); end
    total++; if (pe !== last_pe)   begin bad++; $display("FAIL glitch_pe got=%b exp=%b", pe, last_pe); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int unsigned t0;
    for (int k = 0; k < 2; k++) begin
      evq.delete();
      send_frame(8'h07, (k == 0) ? 1'b1 : 1'b0, 1'b1, t0);
      repeat (CPB) @(negedge clk);
      total++; if (evq.size() !== 1) begin bad++; $display("FAIL par%0d_count got=%0d exp=1", k, evq.size()); end
      if (evq.size() >= 1) begin
        total++; if (evq[0].pe !== (k == 1)) begin bad++; $display("FAIL par%0d_even got=%b exp=%b", k, evq[0].pe, (k == 1)); end
        total++; if (evq[0].po !== (k == 0)) begin bad++; $display("FAIL par%0d_odd got=%b exp=%b", k, evq[0].po, (k == 0)); end
      end
      total++; if (byte2 !== 8'h07) begin bad++; $display("FAIL par%0d_odd_byte got=%h exp=07", k, byte2); end
    end
  endtask
`endif

  task automatic test_reset_midframe;
    int unsigned t0, t1;
    send_frame(8'hC3, ~(^8'hC3), 1'b0, t0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    evq.delete();
    fork
      send_frame(8'hF3, 1'b1, 1'b1, t1);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (dv !== 1'b0)     begin bad++; $display("FAIL midrst_dv got=%b exp=0", dv); end
        total++; if (rbyte !== 8'h00) begin bad++; $display("FAIL midrst_byte got=%h exp=00", rbyte); end
        total++; if (fe !== 1'b0)     begin bad++; $display("FAIL midrst_fe got=%b exp=0", fe); end
        total++; if (pe !== 1'b0)     begin bad++; $display("FAIL midrst_pe got=%b exp=0", pe); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (2 * CPB) @(negedge clk);
    total++; if (evq.size() !== 0) begin bad++; $display("FAIL midrst_partial got=%0d exp=0", evq.size()); end
    send_frame(8'h81, ^8'h81, 1'b1, t0);
    repeat (CPB) @(negedge clk);
    total++; if (evq.size() !== 1) begin bad++; $display("FAIL midrst_next_count got=%0d exp=1", evq.size()); end
    if (evq.size() >= 1) begin
      total++; if (evq[0].b !== 8'h81) begin bad++; $display("FAIL midrst_next_byte got=%h exp=81", evq[0].b); end
      total++; if (evq[0].fe !== 1'b0) begin bad++; $display("FAIL midrst_next_fe got=%b exp=0", evq[0].fe); end
      total++; if (evq[0].pe !== 1'b0) begin bad++; $display("FAIL midrst_next_pe got=%b exp=0", evq[0].pe); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_break;
    test_glitch;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
